rand_server: RTL

- Owns a single 8-bit free-running Galois LFSR and shares it between N_REQ requesters.
- A round-robin arbiter selects one pending requester and captures the current LFSR value.
- A sequential reducer maps that value into the range [0, limit-1] by repeated subtraction, then returns the result with a one-cycle grant pulse.
- Sits between game/display logic and the random source; it is the only block permitted to sample the LFSR.

---
 rtl/rand_server_if.sv | 25 ++
 rtl/rand_server.sv | 132 +++++++++++++
 2 files changed

// File: rtl/rand_server_if.sv
// Request/grant bus between the random server and its requesters, plus
// the seed loading port.
interface rand_server_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) ();
  logic               seed_load;
  logic [W-1:0]       seed;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] limit_flat;
  logic [N_REQ-1:0]   gnt;
  logic               valid;
  logic [W-1:0]       rand_out;
  logic               busy;

  modport master (
    output seed_load, seed, req, limit_flat,
    input  gnt, valid, rand_out, busy
  );

  modport slave (
    input  seed_load, seed, req, limit_flat,
    output gnt, valid, rand_out, busy
  );
endinterface

// File: rtl/rand_server.sv
// Shared 8-bit Galois LFSR served round-robin to N_REQ requesters; each
// captured value is reduced into [0, limit-1] by repeated subtraction.
module rand_server #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic          clk_25M,
  input  logic          rst,
  rand_server_if.slave  bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t             state_reg, state_next;
  logic [W-1:0]       lfsr_reg, lfsr_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [W-1:0]       val_reg, val_next;
  logic [W-1:0]       lim_reg, lim_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [W-1:0]       rand_out_reg, rand_out_next;
  logic               valid_reg, valid_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;

  logic [W-1:0]       lfsr_step;
  logic [IDX_W-1:0]   cand_idx [N_REQ];
  logic [N_REQ-1:0]   cand_hit;
  logic [W-1:0]       limit_arr [N_REQ];
  logic [N_REQ-1:0]   owner_oh;
  logic               grant_hit;
  logic [IDX_W-1:0]   grant_idx;

  assign lfsr_step = {lfsr_reg[6],
                      lfsr_reg[5] ^ lfsr_reg[7],
                      lfsr_reg[4] ^ lfsr_reg[7],
                      lfsr_reg[3] ^ lfsr_reg[7],
                      lfsr_reg[2:0],
                      lfsr_reg[7]};

  // A zero seed would lock the LFSR at zero, so it maps to all-ones.
  always_comb begin
    lfsr_next = lfsr_step;
    if (bus.seed_load)
      lfsr_next = (bus.seed == '0) ? 8'hFF : bus.seed;
  end

  // Candidate gi is the requester gi positions past rr_ptr, wrapped.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum           = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
    assign cand_idx[gi]  = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                                      : sum[IDX_W-1:0];
    assign cand_hit[gi]  = bus.req[cand_idx[gi]];
    assign limit_arr[gi] = bus.limit_flat[gi*W +: W];
    assign owner_oh[gi]  = (owner_reg == IDX_W'(gi));
  end

  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        grant_hit = 1'b1;
        grant_idx = cand_idx[i];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    val_next      = val_reg;
    lim_next      = lim_reg;
    owner_next    = owner_reg;
    rand_out_next = rand_out_reg;
    valid_next    = 1'b0;
    gnt_next      = '0;
    case (state_reg)
      IDLE: begin
        if (grant_hit) begin
          val_next    = lfsr_reg;
          lim_next    = limit_arr[grant_idx];
          owner_next  = grant_idx;
          rr_ptr_next = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_next  = REDUCE;
        end
      end
      REDUCE: begin
        // A zero limit means full range and skips reduction entirely.
        if (lim_reg != '0 && val_reg >= lim_reg) begin
          val_next = val_reg - lim_reg;
        end else begin
          rand_out_next = val_reg;
          valid_next    = 1'b1;
          gnt_next      = owner_oh;
          state_next    = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      lfsr_reg     <= 8'hFF;
      rr_ptr_reg   <= '0;
      val_reg      <= '0;
      lim_reg      <= '0;
      owner_reg    <= '0;
      rand_out_reg <= '0;
      valid_reg    <= 1'b0;
      gnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      lfsr_reg     <= lfsr_next;
      rr_ptr_reg   <= rr_ptr_next;
      val_reg      <= val_next;
      lim_reg      <= lim_next;
      owner_reg    <= owner_next;
      rand_out_reg <= rand_out_next;
      valid_reg    <= valid_next;
      gnt_reg      <= gnt_next;
    end
  end

  assign bus.gnt      = gnt_reg;
  assign bus.valid    = valid_reg;
  assign bus.rand_out = rand_out_reg;
  assign bus.busy     = (state_reg != IDLE);
endmodule
